// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit feeding the HI/LO register pair.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start, op         request and operation (000 MULT, 001 MULTU, 010 DIV,
//                     011 DIVU, 1xx MADD/MADDU/MSUB/MSUBU)
//   src_a, src_b      rs / rt operands
//   hi_in, lo_in      current HI/LO, used only by accumulate ops
//   flush             abort the in-flight operation
//   busy              operation in progress (excluding the finish cycle)
//   finish            one-cycle pulse, hi_out/lo_out valid (HI/LO write enable)
//   hi_out, lo_out    result, held between operations
//
// Parameter MUL_LAT (1..4): multiply latency from start to finish.
// Macro MDU_MADD_EN: enables the accumulate ops (op 1xx); when undefined
// those opcodes are rejected and no accumulate datapath is built.

module mdu_iter #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        flush,
  output logic        busy,
  output logic        finish,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

`ifdef MDU_MADD_EN
  typedef enum logic [2:0] {IDLE, MUL, DIV, ACC, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, MUL, DIV, DONE} state_t;
`endif

  // The hi_out/lo_out register is the final product stage, so only
  // MUL_LAT-1 internal stages are needed (at least one is declared).
  localparam int unsigned PSTG = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  localparam int unsigned PIDX = PSTG - 1;
  localparam logic [5:0]  MUL_LAST = (MUL_LAT > 1) ? 6'(MUL_LAT - 2) : '0;

  state_t      state;
  logic [5:0]  cnt;
  logic [63:0] pipe [PSTG];

  // divide datapath
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [31:0] a_r;
  logic        neg_q;
  logic        neg_r;
  logic        div_zero;

  logic        legal;
  logic        is_div;
  logic        sgn;
  logic [63:0] ma;
  logic [63:0] mb;
  logic [63:0] prod_now;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] q_fin;
  logic [31:0] r_fin;

`ifdef MDU_MADD_EN
  logic [63:0] prod_r;
  logic [31:0] hi_in_r;
  logic [31:0] lo_in_r;
  logic        acc_en;
  logic        acc_sub;
  assign legal = 1'b1;
`else
  logic unused_acc;
  assign unused_acc = ^{hi_in, lo_in};
  assign legal      = ~op[2];
`endif

  assign is_div = ~op[2] & op[1];
  assign sgn    = ~op[0];

  // Operands extended to 64 bits so the product is exact modulo 2^64.
  assign ma       = {{32{sgn & src_a[31]}}, src_a};
  assign mb       = {{32{sgn & src_b[31]}}, src_b};
  assign prod_now = ma * mb;

  assign abs_a = (sgn & src_a[31]) ? -src_a : src_a;
  assign abs_b = (sgn & src_b[31]) ? -src_b : src_b;

  // One restoring step: 33-bit trial subtraction of the shifted remainder.
  always_comb begin
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, dvs};
    if (diff[32]) begin
      rem_nxt = shifted[31:0];
      quo_nxt = {quo[30:0], 1'b0};
    end else begin
      rem_nxt = diff[31:0];
      quo_nxt = {quo[30:0], 1'b1};
    end
    q_fin = neg_q ? -quo_nxt : quo_nxt;
    r_fin = neg_r ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      finish   <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      a_r      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      for (int unsigned i = 0; i < PSTG; i++) pipe[i] <= '0;
`ifdef MDU_MADD_EN
      prod_r   <= '0;
      hi_in_r  <= '0;
      lo_in_r  <= '0;
      acc_en   <= 1'b0;
      acc_sub  <= 1'b0;
`endif
    end else if (flush) begin
      state  <= IDLE;
      busy   <= 1'b0;
      finish <= 1'b0;
    end else begin
      finish <= 1'b0;
      for (int unsigned i = 1; i < PSTG; i++) pipe[i] <= pipe[i-1];
      case (state)
        IDLE: begin
          if (start && legal) begin
            cnt      <= '0;
            pipe[0]  <= prod_now;
            a_r      <= src_a;
            div_zero <= (src_b == '0);
            neg_q    <= sgn & (src_a[31] ^ src_b[31]);
            neg_r    <= sgn & src_a[31];
`ifdef MDU_MADD_EN
            hi_in_r  <= hi_in;
            lo_in_r  <= lo_in;
            acc_en   <= op[2];
            acc_sub  <= op[1];
`endif
            if (is_div) begin
              state <= DIV;
              busy  <= 1'b1;
              rem   <= '0;
              quo   <= abs_a;
              dvs   <= abs_b;
            end else if (MUL_LAT == 1) begin
`ifdef MDU_MADD_EN
              if (op[2]) begin
                state  <= ACC;
                busy   <= 1'b1;
                prod_r <= prod_now;
              end else begin
                state  <= DONE;
                finish <= 1'b1;
                {hi_out, lo_out} <= prod_now;
              end
`else
              state  <= DONE;
              finish <= 1'b1;
              {hi_out, lo_out} <= prod_now;
`endif
            end else begin
              state <= MUL;
              busy  <= 1'b1;
            end
          end
        end

        MUL: begin
          cnt <= cnt + 6'd1;
          if (cnt == MUL_LAST) begin
`ifdef MDU_MADD_EN
            if (acc_en) begin
              state  <= ACC;
              prod_r <= pipe[PIDX];
            end else begin
              state  <= DONE;
              busy   <= 1'b0;
              finish <= 1'b1;
              {hi_out, lo_out} <= pipe[PIDX];
            end
`else
            state  <= DONE;
            busy   <= 1'b0;
            finish <= 1'b1;
            {hi_out, lo_out} <= pipe[PIDX];
`endif
          end
        end

`ifdef MDU_MADD_EN
        ACC: begin
          state  <= DONE;
          busy   <= 1'b0;
          finish <= 1'b1;
          {hi_out, lo_out} <= acc_sub ? ({hi_in_r, lo_in_r} - prod_r)
                                      : ({hi_in_r, lo_in_r} + prod_r);
        end
`endif

        DIV: begin
          cnt <= cnt + 6'd1;
          rem <= rem_nxt;
          quo <= quo_nxt;
          if (cnt == 6'd31) begin
            state  <= DONE;
            busy   <= 1'b0;
            finish <= 1'b1;
            // Divide by zero keeps full latency but overrides the result.
            if (div_zero) begin
              hi_out <= a_r;
              lo_out <= '1;
            end else begin
              hi_out <= r_fin;
              lo_out <= q_fin;
            end
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter. Directed cases plus
// randomized operations compared against an arithmetic reference model.
// Define MDU_MADD_EN for both files to exercise the accumulate ops.

module tb_mdu_iter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [31:0] hi_in = '0;
  logic [31:0] lo_in = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        finish;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int checks = 0;
  int errors = 0;

  mdu_iter #(.MUL_LAT(LAT)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .hi_in  (hi_in),
    .lo_in  (lo_in),
    .flush  (flush),
    .busy   (busy),
    .finish (finish),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: {hi,lo} straight from the arithmetic definition.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] h,
                                            input logic [31:0] l);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (o[2] == 1'b0 && o[1] == 1'b1) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (o[0] == 1'b0) begin
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      return {32'(ua % ub), 32'(ua / ub)};
    end
    p = (o[0] == 1'b0) ? longint'(sa * sb) : ua * ub;
    if (o[2] == 1'b0) return p;
    if (o[1] == 1'b0) return {h, l} + p;
    return {h, l} - p;
  endfunction

  function automatic int ref_lat(input logic [2:0] o);
    if (o[2] == 1'b0 && o[1] == 1'b1) return 33;
    if (o[2] == 1'b1) return LAT + 1;
    return LAT;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Drive a request so it is sampled in cycle T; returns during cycle T+1.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h, input logic [31:0] l);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; hi_in = h; lo_in = l;
    @(posedge clk);
    #1;
    start = 1'b0; src_a = $urandom; src_b = $urandom; hi_in = $urandom; lo_in = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                        input bit stray);
    logic [63:0] exp;
    int n, got_lat, bad_busy, extra;
    exp = ref_model(o, a, b, h, l);
    issue(o, a, b, h, l);
    n = 0; got_lat = 0; bad_busy = 0;
    while (got_lat == 0 && n < 100) begin
      @(negedge clk);
      n++;
      if (finish) begin
        got_lat = n;
        if (busy !== 1'b0) bad_busy++;
      end else if (busy !== 1'b1) bad_busy++;
      start = stray && (n == 5);
      if (stray && n == 5) begin
        op = 3'($urandom_range(0, 3)); src_a = $urandom; src_b = $urandom;
      end
    end
    start = 1'b0;
    check({tag, "_lat"}, 64'(got_lat), 64'(ref_lat(o)));
    check({tag, "_res"}, {hi_out, lo_out}, exp);
    check({tag, "_busy"}, 64'(bad_busy), 64'd0);
    if (stray) begin
      extra = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (finish) extra++;
      end
      check({tag, "_extra_fin"}, 64'(extra), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] prev;
    logic [2:0]  ro;
    int          early, bad;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_finish", 64'(finish), 64'd0);
    check("rst_hilo", {hi_out, lo_out}, 64'd0);

    run_op("mult", 3'b000, 32'hFFFF_FFFF, 32'h2, 0, 0, 0);
    check("mult_const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("multu", 3'b001, 32'hFFFF_FFFF, 32'h2, 0, 0, 0);
    check("multu_const", {hi_out, lo_out}, 64'h0000_0001_FFFF_FFFE);
    run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'h2, 0, 0, 0);
    check("div_neg_const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_zero", 3'b011, 32'd7, 32'd0, 0, 0, 0);
    check("divu_zero_const", {hi_out, lo_out}, 64'h0000_0007_FFFF_FFFF);
    run_op("div_zero", 3'b010, 32'hFFFF_FFF0, 32'd0, 0, 0, 0);
    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    check("div_ovf_const", {hi_out, lo_out}, 64'h0000_0000_8000_0000);
    run_op("stray", 3'b010, 32'hFFFF_FFF9, 32'h2, 0, 0, 1);

    // Flush in T+10, then MULTU 3x5 sampled in T+12.
    prev = {hi_out, lo_out};
    issue(3'b010, 32'd100, 32'd3, 0, 0);
    early = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 11) check("flush_busy", 64'(busy), 64'd0);
      if (n == 12) check("flush_hold", {hi_out, lo_out}, prev);
      if (n <= 13 && finish) early++;
      if (n == 14) begin
        check("flush_mul_fin", 64'(finish), 64'd1);
        check("flush_mul_res", {hi_out, lo_out}, 64'd15);
      end
      flush = (n == 10);
      start = (n == 12);
      if (n == 12) begin op = 3'b001; src_a = 32'd3; src_b = 32'd5; end
    end
    start = 1'b0;
    check("flush_nofin", 64'(early), 64'd0);

    // Reset mid-divide clears the result registers.
    issue(3'b011, 32'd1000, 32'd7, 0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hilo", {hi_out, lo_out}, 64'd0);

`ifdef MDU_MADD_EN
    run_op("madd", 3'b100, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 0);
    check("madd_const", {hi_out, lo_out}, 64'h0000_0001_0000_0000);
    run_op("msub", 3'b110, 32'd1, 32'd1, 32'd0, 32'd0, 0);
    check("msub_const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    run_op("seed", 3'b001, 32'd6, 32'd7, 0, 0, 0);
    prev = {hi_out, lo_out};
    @(negedge clk);
    start = 1'b1; op = 3'b100; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (busy || finish) bad++;
    end
    check("illegal_idle", 64'(bad), 64'd0);
    check("illegal_hold", {hi_out, lo_out}, prev);
`endif

    for (int k = 0; k < 150; k++) begin
`ifdef MDU_MADD_EN
      ro = 3'($urandom_range(0, 7));
`else
      ro = 3'($urandom_range(0, 3));
`endif
      run_op("rnd", ro, pick(), pick(), $urandom, $urandom, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=stuck exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Multi-cycle multiply/divide unit in the EXE stage, directly upstream of the HI/LO register pair. It accepts one MULT/MULTU/DIV/DIVU (and optionally MADD/MSUB) operation per request, computes it over a fixed number of cycles, and delivers the 64-bit result as `hi_out`/`lo_out` with a one-cycle `finish` pulse. `finish` drives the HI/LO write-enable (MULT_DIV_finish). `busy` stalls the front of the pipeline.

## Interface
- `MUL_LAT`, default 2: multiply latency in cycles from start to finish; legal range 1..4.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: issue request; sampled only in IDLE.
- `op` in 3: operation select.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU.
  - 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- `src_a` in 32: multiplicand or dividend (rs).
- `src_b` in 32: multiplier or divisor (rt).
- `hi_in`, `lo_in` in 32 each: current HI/LO contents, used only for accumulate ops.
- `flush` in 1: abort the in-flight operation (exception or redirect).
- `busy` out 1: operation in progress, excluding the finish cycle.
- `finish` out 1: one-cycle pulse; `hi_out`/`lo_out` are valid in that cycle.
- `hi_out`, `lo_out` out 32 each: result; hold their last value between operations.

## Operation
- **States:** IDLE, MUL, DIV, DONE.
  - Reset or `flush` → IDLE.
  - IDLE & `start` & legal op → MUL (op[1]=0) or DIV (op[1]=1).
  - MUL → DONE after MUL_LAT−1 cycles in MUL.
  - DIV → DONE after 32 iteration cycles.
  - DONE → IDLE unconditionally.
- **Capture on accept:** `src_a`, `src_b`, `op`, `hi_in`, `lo_in` are latched; later input changes are ignored.
- **Multiply:** signed or unsigned 32×32 → 64 result. Product pipelined across MUL_LAT register stages.
- **Divide:** restoring radix-2 on absolute values.
  - Datapath: 33-bit partial remainder, 32-bit quotient shift register, 6-bit counter.
  - One quotient bit per cycle.
  - Signed ops: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - `lo_out` = quotient, `hi_out` = remainder.
- **Divide by zero:** no exception; same latency; `lo_out`=32'hFFFF_FFFF, `hi_out`=`src_a` for both DIV and DIVU.
- **Signed overflow** (0x8000_0000 / −1): `lo_out`=0x8000_0000, `hi_out`=0.
- **`start` while not IDLE:** ignored.
- **`flush` and `start` in the same cycle:** `flush` wins; the request is not accepted.
- **Outputs:** `hi_out`/`lo_out` update only at the edge entering DONE. A flushed operation never updates them and never pulses `finish`.

## Timing
- T = the cycle in which `start` is sampled high in IDLE.
- Multiply: `busy` high in T+1..T+MUL_LAT−1; `finish` high in T+MUL_LAT. With MUL_LAT=1, `busy` is never high.
- Divide: `busy` high in T+1..T+32; `finish` high in T+33.
- Back-to-back: a new `start` can be accepted in the cycle after `finish`. Minimum issue interval is MUL_LAT+1 cycles for multiply and 34 cycles for divide.
- `flush` sampled high at an edge: state is IDLE, `busy`=0 and `finish`=0 from the next cycle.
- Reset values: `busy`=0, `finish`=0, `hi_out`=0, `lo_out`=0, state IDLE, counter 0.
- `rst` asserted mid-operation behaves identically to `flush` and additionally clears `hi_out`/`lo_out`.

## Configuration
- **`MDU_MADD_EN` defined:** op 1xx is supported.
  - MADD/MADDU: result = {hi_in,lo_in} + product (signed or unsigned as in MULT/MULTU).
  - MSUB/MSUBU: result = {hi_in,lo_in} − product.
  - Arithmetic is 64-bit, modulo 2^64.
  - One extra cycle: `finish` in T+MUL_LAT+1 and `busy` through T+MUL_LAT.
- **`MDU_MADD_EN` undefined:** op 1xx is illegal. `start` is ignored, no state change, no `finish`, and no accumulate logic is present.

## Test plan
- MULT 0xFFFF_FFFF × 0x0000_0002, MUL_LAT=2 → `finish` in T+2, hi=0xFFFF_FFFF, lo=0xFFFF_FFFE. MULTU with the same operands → hi=0x0000_0001, lo=0xFFFF_FFFE.
- DIV −7 / 2 → `busy` in T+1..T+32, `finish` in T+33, lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- DIVU 7 / 0 → lo=0xFFFF_FFFF, hi=7.
- DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- DIV 100/3 with `flush` in T+10 → `busy`=0 from T+11, no `finish`, outputs unchanged. A MULTU 3×5 started in T+12 → `finish` in T+14, lo=15, hi=0.
- `start` pulsed in T+5 during a DIV → ignored; exactly one `finish`, in T+33.
- With `MDU_MADD_EN`: MADD with hi_in=0, lo_in=0xFFFF_FFFF, 1×1 → hi=1, lo=0, `finish` in T+3. MSUB with hi_in=0, lo_in=0, 1×1 → hi=lo=0xFFFF_FFFF.
- Without `MDU_MADD_EN`: op=100 → `busy` stays 0 and no `finish`.
